// File: rtl/ccd_line_capture_pkg.sv
// Shared linear-CCD definitions: capture FSM state encoding and the line timing
// defaults also used by the SH gate generator.
package ccd_line_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_CONV = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam int CCD_DATA_W      = 12;
  localparam int CCD_NUM_PIXELS  = 3648;
  localparam int CCD_DUMMY_PIX   = 32;
  localparam int CCD_PIX_DIV     = 100;
  localparam int CCD_ADC_TIMEOUT = 64;
  localparam int CCD_IDX_W       = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccd_pix_outreg.sv
// One-deep valid/ready pixel output register; loads the cycle a word is offered,
// passes through on same-cycle drain, and flags a drop when full and stalled.
module ccd_pix_outreg #(
  parameter int DATA_W = 12,
  parameter int IDX_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_vld,
  input  logic [DATA_W-1:0] i_ld_dat,
  input  logic [IDX_W-1:0]  i_ld_idx,
  input  logic              i_ld_sol,
  input  logic              i_ld_eol,
  input  logic              i_rdy,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_sol,
  output logic              o_eol,
  output logic              o_drop
);

  logic              r_vld;
  logic [DATA_W-1:0] r_dat;
  logic [IDX_W-1:0]  r_idx;
  logic              r_sol;
  logic              r_eol;
  logic              w_accept;

  assign w_accept = i_ld_vld & (~r_vld | i_rdy);
  assign o_drop   = i_ld_vld & r_vld & ~i_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_idx <= '0;
      r_sol <= 1'b0;
      r_eol <= 1'b0;
    end else if (w_accept) begin
      r_vld <= 1'b1;
      r_dat <= i_ld_dat;
      r_idx <= i_ld_idx;
      r_sol <= i_ld_sol;
      r_eol <= i_ld_eol;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;
  assign o_idx = r_idx;
  assign o_sol = r_sol;
  assign o_eol = r_eol;

endmodule

// File: rtl/ccd_line_capture.sv
// Linear-CCD line capture: on SH fall skips dummy pixels, paces one ADC conversion
// per pixel period and streams tagged words; output word appears 2 cycles after adc_done.
module ccd_line_capture
  import ccd_line_capture_pkg::*;
#(
  parameter int DATA_W      = CCD_DATA_W,
  parameter int NUM_PIXELS  = CCD_NUM_PIXELS,
  parameter int DUMMY_PIX   = CCD_DUMMY_PIX,
  parameter int PIX_DIV     = CCD_PIX_DIV,
  parameter int ADC_TIMEOUT = CCD_ADC_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sh_in,
  output logic              o_adc_start,
  input  logic              i_adc_done,
  input  logic [DATA_W-1:0] i_adc_data,
  output logic [DATA_W-1:0] o_pix_data,
  output logic [15:0]       o_pix_idx,
  output logic              o_pix_sol,
  output logic              o_pix_eol,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_busy,
  input  logic              i_clr_err,
  output logic              o_overflow,
  output logic              o_adc_tmo,
  output logic              o_line_err
);

  localparam int DIV_W  = cnt_w(PIX_DIV);
  localparam int WCNT_W = cnt_w(ADC_TIMEOUT + 1);

  if (PIX_DIV <= ADC_TIMEOUT + 2) begin : g_bad_timing
    $error("ccd_line_capture: PIX_DIV must exceed ADC_TIMEOUT+2");
  end
  if (NUM_PIXELS < 1 || NUM_PIXELS > 65536) begin : g_bad_pixels
    $error("ccd_line_capture: NUM_PIXELS out of range");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_sh_d;
  logic                r_sh_arm;
  logic [DIV_W-1:0]    r_div;
  logic [15:0]         r_skip;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [15:0]         r_idx;
  logic                r_ld_vld;
  logic [DATA_W-1:0]   r_ld_dat;
  logic [15:0]         r_ld_idx;
  logic                r_ld_sol;
  logic                r_ld_eol;
  logic                r_ovf;
  logic                r_tmo;
  logic                r_lerr;
  logic                w_sh_fall;
  logic                w_tick;
  logic                w_last;
  logic                w_start;
  logic                w_done_evt;
  logic                w_tmo_evt;
  logic                w_drop;

  // Arming requires SH to be seen high after reset, so a low SH at reset release
  // never looks like an end-of-shift edge.
  assign w_sh_fall = r_sh_arm & r_sh_d & ~i_sh_in;
  // The tick marks the first cycle of each pixel period, one cycle after SH fall.
  assign w_tick    = (r_div == DIV_W'(PIX_DIV - 1));
  assign w_last    = (r_idx == 16'(NUM_PIXELS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done_evt  = 1'b0;
    w_tmo_evt   = 1'b0;
    if (w_sh_fall) begin
      w_state_nxt = (DUMMY_PIX > 0) ? ST_SKIP : ST_CONV;
    end else begin
      case (r_state)
        ST_SKIP: begin
          if (w_tick && r_skip == 16'(DUMMY_PIX - 1)) w_state_nxt = ST_CONV;
        end
        ST_CONV: begin
          if (w_tick) begin
            w_start     = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_adc_done || r_wcnt == WCNT_W'(ADC_TIMEOUT)) begin
            w_done_evt  = 1'b1;
            w_tmo_evt   = ~i_adc_done;
            w_state_nxt = w_last ? ST_IDLE : ST_CONV;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_sh_d   <= 1'b1;
      r_sh_arm <= 1'b0;
      r_div    <= '0;
      r_skip   <= '0;
      r_wcnt   <= '0;
      r_idx    <= '0;
      r_ld_vld <= 1'b0;
      r_ld_dat <= '0;
      r_ld_idx <= '0;
      r_ld_sol <= 1'b0;
      r_ld_eol <= 1'b0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
      r_lerr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sh_d  <= i_sh_in;
      if (i_sh_in) r_sh_arm <= 1'b1;

      if (w_sh_fall || r_div == '0) r_div <= DIV_W'(PIX_DIV - 1);
      else                          r_div <= r_div - DIV_W'(1);

      if (w_sh_fall)                         r_skip <= '0;
      else if (r_state == ST_SKIP && w_tick) r_skip <= r_skip + 16'd1;

      if (w_start)                 r_wcnt <= WCNT_W'(1);
      else if (r_state == ST_WAIT) r_wcnt <= r_wcnt + WCNT_W'(1);

      if (w_sh_fall)       r_idx <= '0;
      else if (w_done_evt) r_idx <= r_idx + 16'd1;

      // Timed-out pixels still produce an all-ones word so line length is kept.
      r_ld_vld <= w_done_evt;
      if (w_done_evt) begin
        r_ld_dat <= w_tmo_evt ? '1 : i_adc_data;
        r_ld_idx <= r_idx;
        r_ld_sol <= (r_idx == 16'd0);
        r_ld_eol <= w_last;
      end

      r_ovf  <= i_clr_err ? 1'b0 : (r_ovf | w_drop);
      r_tmo  <= i_clr_err ? 1'b0 : (r_tmo | w_tmo_evt);
      r_lerr <= i_clr_err ? 1'b0 : (r_lerr | (w_sh_fall && r_state != ST_IDLE));
    end
  end

  ccd_pix_outreg #(
    .DATA_W (DATA_W),
    .IDX_W  (16)
  ) u_outreg (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ld_vld (r_ld_vld),
    .i_ld_dat (r_ld_dat),
    .i_ld_idx (r_ld_idx),
    .i_ld_sol (r_ld_sol),
    .i_ld_eol (r_ld_eol),
    .i_rdy    (i_pix_ready),
    .o_vld    (o_pix_valid),
    .o_dat    (o_pix_data),
    .o_idx    (o_pix_idx),
    .o_sol    (o_pix_sol),
    .o_eol    (o_pix_eol),
    .o_drop   (w_drop)
  );

  assign o_adc_start = w_start;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_overflow  = r_ovf;
  assign o_adc_tmo   = r_tmo;
  assign o_line_err  = r_lerr;

endmodule

// File: tb/tb_ccd_line_capture.sv
// Bench for ccd_line_capture: ADC model answers 2 cycles after each start and
// pushes the expected word; the stream monitor pops and compares on each transfer.
module tb_ccd_line_capture;

  localparam int DW  = 12;
  localparam int NP  = 4;
  localparam int DP  = 2;
  localparam int PD  = 8;
  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sh_in, adc_done, pix_ready, clr_err;
  logic [DW-1:0] adc_data;
  logic          adc_start, pix_sol, pix_eol, pix_valid, busy, overflow, adc_tmo, line_err;
  logic [DW-1:0] pix_data;
  logic [15:0]   pix_idx;

  ccd_line_capture #(
    .DATA_W(DW), .NUM_PIXELS(NP), .DUMMY_PIX(DP), .PIX_DIV(PD), .ADC_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sh_in(sh_in),
    .o_adc_start(adc_start), .i_adc_done(adc_done), .i_adc_data(adc_data),
    .o_pix_data(pix_data), .o_pix_idx(pix_idx), .o_pix_sol(pix_sol), .o_pix_eol(pix_eol),
    .o_pix_valid(pix_valid), .i_pix_ready(pix_ready), .o_busy(busy),
    .i_clr_err(clr_err), .o_overflow(overflow), .o_adc_tmo(adc_tmo), .o_line_err(line_err)
  );

  typedef struct {
    logic [DW-1:0] dat;
    int            idx;
    logic          sol;
    logic          eol;
  } word_t;

  typedef struct {
    logic rdy;
    int   supp;
    int   exp_ovf;
    int   exp_tmo;
    int   exp_xfer;
  } row_t;

  word_t sb_q[$];
  int    start_q[$];
  int    nvec = 0, nmis = 0, cyc = 0;
  int    m_idx = 0, supp_idx = -1, n_xfer = 0, busy_fall = -1;
  int    xfer_cyc[NP];
  logic  busy_prev = 1'b0;
  logic [1:0] st_hist = 2'b00;
  int    n, n2;
  row_t  tbl[3];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample the current cycle at negedge, then advance to the next cycle and
  // drive the ADC model.
  task automatic clk_cycle();
    word_t w;
    @(negedge clk);
    if (adc_start) start_q.push_back(cyc);
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
    if (pix_valid && pix_ready) begin
      chk("sb_nonempty", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        w = sb_q.pop_front();
        chk("pix_data", int'(pix_data), int'(w.dat));
        chk("pix_idx", int'(pix_idx), w.idx);
        chk("pix_sol", int'(pix_sol), int'(w.sol));
        chk("pix_eol", int'(pix_eol), int'(w.eol));
      end
      n_xfer++;
      if (pix_idx < NP) xfer_cyc[pix_idx] = cyc;
    end
    st_hist = {st_hist[0], adc_start};
    @(posedge clk);
    #1;
    cyc++;
    adc_done = 1'b0;
    if (st_hist[1]) begin
      w.idx = m_idx;
      w.sol = (m_idx == 0);
      w.eol = (m_idx == NP - 1);
      if (m_idx == supp_idx) begin
        w.dat = '1;
      end else begin
        adc_data = DW'($urandom_range(0, 4094));
        adc_done = 1'b1;
        w.dat    = adc_data;
      end
      sb_q.push_back(w);
      m_idx++;
    end
  endtask

  task automatic line_start(output int nf);
    sh_in = 1'b1;
    repeat (3) clk_cycle();
    sh_in = 1'b0;
    m_idx = 0;
    start_q.delete();
    n_xfer = 0;
    busy_fall = -1;
    for (int i = 0; i < NP; i++) xfer_cyc[i] = -1;
    nf = cyc;
    clk_cycle();
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    clk_cycle();
    clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sh_in = 1'b1; adc_done = 1'b0; adc_data = '0;
    pix_ready = 1'b1; clr_err = 1'b0;
    repeat (3) clk_cycle();
    chk("rst_outs", int'({adc_start, pix_sol, pix_eol, pix_valid, busy, overflow, adc_tmo, line_err}), 0);
    chk("rst_data", int'(pix_data), 0);
    chk("rst_idx", int'(pix_idx), 0);
    rst = 1'b0;

    // Whole-line scenarios: normal, stalled stream, missing adc_done on idx2.
    tbl[0] = '{1'b1, -1, 0, 0, 4};
    tbl[1] = '{1'b0, -1, 1, 0, 0};
    tbl[2] = '{1'b1,  2, 0, 1, 4};
    for (int r = 0; r < 3; r++) begin
      pix_ready = tbl[r].rdy;
      supp_idx  = tbl[r].supp;
      line_start(n);
      repeat (60) clk_cycle();
      chk("start_cnt", start_q.size(), NP);
      for (int k = 0; k < start_q.size() && k < NP; k++)
        chk("start_cyc", start_q[k] - n, 1 + DP * PD + PD * k);
      chk("busy_fall", busy_fall - n, 1 + DP * PD + PD * (NP - 1) + 3);
      chk("overflow", int'(overflow), tbl[r].exp_ovf);
      chk("adc_tmo", int'(adc_tmo), tbl[r].exp_tmo);
      chk("line_err", int'(line_err), 0);
      chk("xfer_cnt", n_xfer, tbl[r].exp_xfer);
      if (!tbl[r].rdy) begin
        clear_flags();
        chk("ovf_cleared", int'(overflow), 0);
        chk("held_valid", int'(pix_valid), 1);
        chk("held_idx", int'(pix_idx), 0);
        pix_ready = 1'b1;
        repeat (4) clk_cycle();
        chk("drain_xfer", n_xfer, 1);
        chk("dropped_left", sb_q.size(), NP - 1);
      end else begin
        chk("sb_empty", sb_q.size(), 0);
      end
      sb_q.delete();
      supp_idx = -1;
      clear_flags();
      chk("tmo_cleared", int'(adc_tmo), 0);
    end

    // Ready rises exactly in the cycle idx1 loads: both words, back to back.
    pix_ready = 1'b0;
    line_start(n);
    while (cyc < n + 28) clk_cycle();
    pix_ready = 1'b1;
    repeat (40) clk_cycle();
    chk("pass_x0", xfer_cyc[0] - n, 28);
    chk("pass_x1", xfer_cyc[1] - n, 29);
    chk("pass_ovf", int'(overflow), 0);
    chk("pass_xfer", n_xfer, NP);
    chk("pass_sb", sb_q.size(), 0);

    // Second SH fall after idx1: line abandoned and restarted from idx0.
    line_start(n);
    while (cyc < n + 30) clk_cycle();
    sh_in = 1'b1;
    clk_cycle();
    sh_in = 1'b0;
    m_idx = 0;
    n2 = cyc;
    repeat (60) clk_cycle();
    chk("restart_lerr", int'(line_err), 1);
    chk("restart_starts", start_q.size(), 2 + NP);
    if (start_q.size() > 2) chk("restart_first", start_q[2] - n2, 1 + DP * PD);
    chk("restart_xfer", n_xfer, 2 + NP);
    chk("restart_sb", sb_q.size(), 0);
    clear_flags();
    chk("lerr_cleared", int'(line_err), 0);

    // Reset during WAIT with a word held: everything drops to zero, no restart.
    pix_ready = 1'b0;
    line_start(n);
    while (cyc < n + 26) clk_cycle();
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_valid", int'(pix_valid), 1);
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    chk("midrst_outs", int'({adc_start, pix_sol, pix_eol, pix_valid, busy, overflow, adc_tmo, line_err}), 0);
    chk("midrst_data", int'(pix_data), 0);
    start_q.delete();
    repeat (30) clk_cycle();
    chk("post_rst_starts", start_q.size(), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_valid", int'(pix_valid), 0);
    sb_q.delete();

    // clr_err held while drops occur: clearing wins over setting.
    pix_ready = 1'b0;
    clr_err = 1'b1;
    line_start(n);
    repeat (50) clk_cycle();
    chk("clr_prio_ovf", int'(overflow), 0);
    clr_err = 1'b0;
    pix_ready = 1'b1;
    repeat (4) clk_cycle();
    chk("clr_prio_xfer", n_xfer, 1);
    chk("clr_prio_ovf2", int'(overflow), 0);
    sb_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
